mc_seq_ctrl: RTL

- Multi-cycle sequencer for the RV32I datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues the per-cycle write enables (PC, IR, register file, data memory).
- Runs the imem/dmem request/ready handshakes, with a stall timeout.
- The combinational decoder still supplies EXTOp/ALUOp/ALUSrc/WDSel/DMType. This block owns timing and NPCOp only.

---
 rtl/mc_seq_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle RV32I sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// runs the imem/dmem handshakes with a stall timeout, and counts retired instructions.
module mc_seq_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       Op,
  input  logic             Zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             IRWrite,
  output logic             dmem_req,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             PCWrite,
  output logic [2:0]       NPCOp,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  // state | meaning
  // FETCH | request imem, load IR when ready
  // DECODE| classify opcode, trap if illegal
  // EXEC  | resolve branches, route to MEM or WB
  // MEM   | dmem handshake, stores retire here
  // WB    | register write and PC update
  // TRAP  | sticky halt until reset
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;

  always_comb begin
    is_r     = (Op == 7'b0110011);
    is_i     = (Op == 7'b0010011);
    is_ld    = (Op == 7'b0000011);
    is_st    = (Op == 7'b0100011);
    is_br    = (Op == 7'b1100011);
    is_jal   = (Op == 7'b1101111);
    is_jalr  = (Op == 7'b1100111);
    is_lui   = (Op == 7'b0110111);
    is_auipc = (Op == 7'b0010111);
    legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
  end

  logic       imem_req_c, irwrite_c, dmem_req_c, memwrite_c, regwrite_c, pcwrite_c;
  logic [2:0] npc_c;
  logic       timed_out;

  assign timed_out = (wait_q == WAIT_MAX);

  always_comb begin
    state_d    = state_q;
    imem_req_c = 1'b0;
    irwrite_c  = 1'b0;
    dmem_req_c = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    pcwrite_c  = 1'b0;
    npc_c      = NPC_PLUS4;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          irwrite_c = 1'b1;
          state_d   = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_br) begin
          pcwrite_c = 1'b1;
          npc_c     = Zero ? NPC_BRANCH : NPC_PLUS4;
          state_d   = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        memwrite_c = is_st;
        if (dmem_ready) begin
          if (is_st) begin
            pcwrite_c = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        regwrite_c = 1'b1;
        pcwrite_c  = 1'b1;
        npc_c      = is_jal ? NPC_JUMP : (is_jalr ? NPC_JALR : NPC_PLUS4);
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // The wait counter only advances while a handshake is stalled; any transition clears it.
  always_comb begin
    if (state_d != state_q)
      wait_d = '0;
    else if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))
      wait_d = wait_q + WAIT_W'(1);
    else
      wait_d = wait_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (pcwrite_c)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Strobes are masked combinationally so a reset abandons the access in the same cycle.
  assign imem_req = rstn & imem_req_c;
  assign IRWrite  = rstn & irwrite_c;
  assign dmem_req = rstn & dmem_req_c;
  assign MemWrite = rstn & memwrite_c;
  assign RegWrite = rstn & regwrite_c;
  assign PCWrite  = rstn & pcwrite_c;
  assign NPCOp    = rstn ? npc_c : NPC_PLUS4;
  assign trap     = (state_q == S_TRAP);
  assign state    = state_q;
  assign instret  = instret_q;

  a_ir_excl: assert property (@(posedge clk) !(IRWrite && (RegWrite || PCWrite)));
  a_rw_wb:   assert property (@(posedge clk) RegWrite |-> (PCWrite && state_q == S_WB));
  a_mw_qual: assert property (@(posedge clk) MemWrite |-> dmem_req);

endmodule
